// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the Risco-5 fetch-stage program
//               counter: default configuration constants and the next-PC
//               source select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int c_DEF_WIDTH        = 32;
    localparam int c_DEF_STEP         = 4;
    localparam int c_DEF_RESET_VECTOR = 0;
    localparam int c_DEF_RAS_DEPTH    = 4;

    // Source of the next PC value.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_RET  = 2'd1,
        PC_LOAD = 2'd2,
        PC_INC  = 2'd3
    } pc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular LIFO used as a return-address stack. A push while
//               full overwrites the oldest entry and leaves the count at
//               DEPTH. A pop while empty is ignored. Pop wins over push when
//               both are requested. rst clears the stack synchronously.
// Ports       : clk, rst          - clock / synchronous active-high clear
//               i_push, i_pop     - stack operations
//               i_push_data       - value pushed
//               o_top             - most recently pushed valid entry
//               o_count           - number of valid entries (0..DEPTH)
//               o_empty, o_full   - count == 0 / count == DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [WIDTH-1:0]        i_push_data,
    output logic [WIDTH-1:0]        o_top,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full
);

    localparam int                 c_PTR_W      = $clog2(DEPTH);
    localparam int                 c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;     // next slot to write
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_top_ptr;
    logic               w_do_pop;
    logic               w_do_push;

    // The pointer wraps naturally because DEPTH is a power of two; when the
    // stack is full the write slot is the oldest entry, so a push overwrites it.
    assign w_top_ptr = r_wr_ptr - c_PTR_W'(1);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & ~i_pop;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_do_pop) begin
            r_wr_ptr <= w_top_ptr;
            r_count  <= r_count - c_CNT_W'(1);
        end else if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (!o_full) begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end
    end

    assign o_top   = r_mem[w_top_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL_COUNT);

endmodule : ras_stack
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Parametrised fetch-stage program counter with stall, fixed
//               next-PC priority (reset > stall > ret > load > inc > hold),
//               misalignment flag and optional return-address stack.
//               Optional feature macro: PC_RAS_EN (enables RAS, call/ret
//               handling and ret_underflow).
// Ports       : clk, reset          - clock / synchronous active-high reset
//               stall               - hold all state
//               inc, load, target   - advance by STEP / load target
//               call, ret           - push return address / pop into pc
//               pc, misaligned      - current pc and its alignment flag
//               ras_count, ras_empty, ras_full, ret_underflow - RAS status
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import pc_pkg::*;
#(
    parameter int               WIDTH        = c_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(c_DEF_RESET_VECTOR),
    parameter int               STEP         = c_DEF_STEP,
    parameter int               RAS_DEPTH    = c_DEF_RAS_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        inc,
    input  logic                        load,
    input  logic [WIDTH-1:0]            target,
    input  logic                        call,
    input  logic                        ret,
    output logic [WIDTH-1:0]            pc,
    output logic                        misaligned,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ret_underflow
);

    localparam int               c_LSB_W = $clog2(STEP);
    localparam logic [WIDTH-1:0] c_STEP  = WIDTH'(STEP);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;
    logic             w_ret_req;
    logic             w_call_req;
    logic             w_push;
    logic             w_pop;
    logic             w_underflow_set;
    pc_sel_e          w_sel;

    // Also the return address for a call: pc+STEP of the pre-update pc.
    assign w_pc_inc = r_pc + c_STEP;

    always_comb begin
        w_sel           = PC_HOLD;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_underflow_set = 1'b0;
        if (!stall) begin
            if (w_ret_req) begin
                // An empty-stack ret still claims the cycle: load/inc are dropped.
                if (!w_ras_empty) begin
                    w_sel = PC_RET;
                    w_pop = 1'b1;
                end else begin
                    w_underflow_set = 1'b1;
                end
            end else if (load) begin
                w_sel  = PC_LOAD;
                w_push = w_call_req;
            end else if (inc) begin
                w_sel = PC_INC;
            end
        end
    end

    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            PC_RET:  w_pc_next = w_ras_top;
            PC_LOAD: w_pc_next = target;
            PC_INC:  w_pc_next = w_pc_inc;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

    generate
        if (c_LSB_W == 0) begin : g_mis_none
            assign misaligned = 1'b0;
        end else begin : g_mis_chk
            assign misaligned = |r_pc[c_LSB_W-1:0];
        end
    endgenerate

`ifdef PC_RAS_EN
    logic r_ret_underflow;

    assign w_ret_req  = ret;
    assign w_call_req = call;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_count     (ras_count),
        .o_empty     (w_ras_empty),
        .o_full      (ras_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ret_underflow <= 1'b0;
        end else if (w_underflow_set) begin
            r_ret_underflow <= 1'b1;
        end
    end

    assign ras_empty     = w_ras_empty;
    assign ret_underflow = r_ret_underflow;
`else
    logic w_unused;

    assign w_ret_req     = 1'b0;
    assign w_call_req    = 1'b0;
    assign w_ras_top     = '0;
    assign w_ras_empty   = 1'b1;
    assign ras_count     = '0;
    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
    assign ret_underflow = 1'b0;
    assign w_unused      = ^{call, ret, w_push, w_pop, w_underflow_set};
`endif

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Directed self-checking bench for program_counter with the
//               default configuration (WIDTH=32, STEP=4, RESET_VECTOR=0,
//               RAS_DEPTH=4). RAS-specific expectations follow PC_RAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        inc;
    logic        load;
    logic [31:0] target;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic        misaligned;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ret_underflow;

    int n_vec;
    int n_err;

    program_counter #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0),
        .STEP         (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .inc           (inc),
        .load          (load),
        .target        (target),
        .call          (call),
        .ret           (ret),
        .pc            (pc),
        .misaligned    (misaligned),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ret_underflow (ret_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of controls across one rising edge; outputs settle #1 later.
    task automatic cyc(input logic rs, input logic st, input logic in_c,
                       input logic ld, input logic [31:0] tg,
                       input logic cl, input logic rt);
        reset  = rs;
        stall  = st;
        inc    = in_c;
        load   = ld;
        target = tg;
        call   = cl;
        ret    = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        stall  = 1'b0;
        inc    = 1'b0;
        load   = 1'b0;
        target = '0;
        call   = 1'b0;
        ret    = 1'b0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 32'h0, 0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        chk("rst_cnt", {29'b0, ras_count}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_full", {31'b0, ras_full}, 32'h0);
        chk("rst_uf", {31'b0, ret_underflow}, 32'h0);

        // Increment sequence
        cyc(0, 0, 1, 0, 32'h0, 0, 0);
        chk("inc1", pc, 32'h4);
        cyc(0, 0, 1, 0, 32'h0, 0, 0);
        chk("inc2", pc, 32'h8);
        cyc(0, 0, 1, 0, 32'h0, 0, 0);
        chk("inc3", pc, 32'hC);
        chk("inc3_mis", {31'b0, misaligned}, 32'h0);

        // Misaligned load, increment, realign
        cyc(0, 0, 0, 1, 32'd47, 0, 0);
        chk("ld47_pc", pc, 32'd47);
        chk("ld47_mis", {31'b0, misaligned}, 32'h1);
        cyc(0, 0, 1, 0, 32'h0, 0, 0);
        chk("ld47_inc", pc, 32'd51);
        chk("ld47_inc_mis", {31'b0, misaligned}, 32'h1);
        cyc(0, 0, 0, 1, 32'h40, 0, 0);
        chk("ld40_pc", pc, 32'h40);
        chk("ld40_mis", {31'b0, misaligned}, 32'h0);

        // Load with call from 0x100
        cyc(0, 0, 0, 1, 32'h100, 0, 0);
        chk("ld100", pc, 32'h100);
        cyc(0, 0, 0, 1, 32'h200, 1, 0);
        chk("call200_pc", pc, 32'h200);
`ifdef PC_RAS_EN
        chk("call200_cnt", {29'b0, ras_count}, 32'h1);
        chk("call200_empty", {31'b0, ras_empty}, 32'h0);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        chk("ret104_pc", pc, 32'h104);
        chk("ret104_empty", {31'b0, ras_empty}, 32'h1);

        // Five nested calls; the fifth overwrites the oldest return address
        cyc(0, 0, 0, 1, 32'h10, 0, 0);
        cyc(0, 0, 0, 1, 32'h20, 1, 0);
        cyc(0, 0, 0, 1, 32'h30, 1, 0);
        cyc(0, 0, 0, 1, 32'h40, 1, 0);
        chk("nest3_cnt", {29'b0, ras_count}, 32'h3);
        cyc(0, 0, 0, 1, 32'h50, 1, 0);
        chk("nest4_full", {31'b0, ras_full}, 32'h1);
        cyc(0, 0, 0, 1, 32'h60, 1, 0);
        chk("nest5_pc", pc, 32'h60);
        chk("nest5_full", {31'b0, ras_full}, 32'h1);
        chk("nest5_cnt", {29'b0, ras_count}, 32'h4);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        chk("pop1", pc, 32'h54);
        chk("pop1_cnt", {29'b0, ras_count}, 32'h3);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        chk("pop2", pc, 32'h44);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        chk("pop3", pc, 32'h34);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        chk("pop4", pc, 32'h24);
        chk("pop4_empty", {31'b0, ras_empty}, 32'h1);
        chk("pop4_uf", {31'b0, ret_underflow}, 32'h0);
        // Underflow: inc and load in the same cycle are dropped
        cyc(0, 0, 1, 1, 32'h999, 0, 1);
        chk("uflow_pc", pc, 32'h24);
        chk("uflow_flag", {31'b0, ret_underflow}, 32'h1);
        chk("uflow_cnt", {29'b0, ras_count}, 32'h0);
`else
        chk("call200_cnt", {29'b0, ras_count}, 32'h0);
        chk("call200_empty", {31'b0, ras_empty}, 32'h1);
        // ret is not present: inc in the same cycle is taken
        cyc(0, 0, 1, 0, 32'h0, 0, 1);
        chk("noras_ret_inc", pc, 32'h204);
        chk("noras_uf", {31'b0, ret_underflow}, 32'h0);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        chk("noras_ret_hold", pc, 32'h204);
        chk("noras_full", {31'b0, ras_full}, 32'h0);
        cyc(0, 0, 0, 1, 32'h24, 0, 0);
        chk("noras_ld24", pc, 32'h24);
`endif

        // Stall overrides load
        cyc(0, 1, 0, 1, 32'h80, 0, 0);
        chk("stall_pc", pc, 32'h24);
        cyc(0, 1, 1, 1, 32'h80, 1, 1);
        chk("stall_all_pc", pc, 32'h24);
`ifdef PC_RAS_EN
        chk("stall_uf", {31'b0, ret_underflow}, 32'h1);
        chk("stall_cnt", {29'b0, ras_count}, 32'h0);
`endif

        // Reset overrides a simultaneous load
        cyc(1, 0, 0, 1, 32'h80, 1, 0);
        chk("rst_ld_pc", pc, 32'h0);
        chk("rst_ld_cnt", {29'b0, ras_count}, 32'h0);
        chk("rst_ld_uf", {31'b0, ret_underflow}, 32'h0);

        // Wrap-around
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_ld", pc, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 0, 32'h0, 0, 0);
        chk("wrap_inc", pc, 32'h0);

`ifdef PC_RAS_EN
        // ret and call together pop only
        cyc(0, 0, 0, 1, 32'h300, 1, 0);
        cyc(0, 0, 0, 1, 32'h400, 1, 0);
        chk("pre_rc_cnt", {29'b0, ras_count}, 32'h2);
        cyc(0, 0, 0, 1, 32'h500, 1, 1);
        chk("rc_pc", pc, 32'h304);
        chk("rc_cnt", {29'b0, ras_count}, 32'h1);
        // call without load is ignored
        cyc(0, 0, 1, 0, 32'h0, 1, 0);
        chk("call_noload_pc", pc, 32'h308);
        chk("call_noload_cnt", {29'b0, ras_count}, 32'h1);
        cyc(0, 0, 0, 0, 32'h0, 0, 1);
        chk("last_pop", pc, 32'h4);
`else
        cyc(0, 0, 0, 1, 32'h300, 1, 1);
        chk("noras_rc_pc", pc, 32'h300);
        chk("noras_rc_cnt", {29'b0, ras_count}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_program_counter
`default_nettype wire
